// File: rtl/alarm_pkg.sv
// Shared types for the alarm switch poller: FSM state encoding and defaults.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2,
    EVAL = 2'd3
  } poll_state_e;

  localparam int DATA_W_DEFAULT = 2;
  // Stable counter width; STABLE_POLLS is limited to 1..15.
  localparam int SCNT_W         = 4;

endpackage

// File: rtl/alarm_debounce_cnt.sv
// Debounce for polled switch samples: a value must repeat STABLE_POLLS times
// in a row before it is accepted, and the accepted value's edges are reported
// as one-cycle pulses.
module alarm_debounce_cnt
  import alarm_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int STABLE_POLLS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] sw_state,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall,
  output logic              sw_changed
);

  localparam logic [SCNT_W-1:0] STABLE = SCNT_W'(STABLE_POLLS);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [SCNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [DATA_W-1:0] rise_q, rise_d;
  logic [DATA_W-1:0] fall_q, fall_d;
  logic              chg_q;

  // Next candidate/counter; the accepted value updates on the same edge the
  // stable count is reached, so it shows up in the cycle after EVAL.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    if (sample_valid) begin
      if (sample == cand_q) begin
        if (cnt_q != STABLE) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = sample;
        cnt_d  = SCNT_W'(1);
      end
      if (cnt_d == STABLE && cand_d != state_q) begin
        state_d = cand_d;
        rise_d  = cand_d & ~state_q;
        fall_d  = ~cand_d & state_q;
      end
    end
  end

  // Debounce state and registered edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= (|rise_d) | (|fall_d);
    end
  end

  assign sw_state   = state_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = chg_q;

endmodule

// File: rtl/alarm_pio_poller.sv
// Avalon-MM master that periodically reads a PIO data register and debounces
// the low DATA_W bits into a stable switch value with edge pulses.
module alarm_pio_poller
  import alarm_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_POLLS = 4,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sw_state,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall,
  output logic              sw_changed
);

  localparam int            CW     = $clog2(POLL_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

  poll_state_e       state_q;
  logic [CW-1:0]     div_q;
  logic              read_q;
  logic [DATA_W-1:0] sample_q;
  logic              sample_vld_q;

  // Only the switch bits matter; the rest of the register is don't-care.
  logic unused_hi;
  assign unused_hi = ^avm_readdata[31:DATA_W];

  // Poll FSM: interval count, one read, capture at fixed latency 1, evaluate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      div_q        <= RELOAD;
      read_q       <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      sample_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!enable) begin
            div_q <= RELOAD;
          end else if (div_q == '0) begin
            div_q   <= RELOAD;
            read_q  <= 1'b1;
            state_q <= REQ;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        REQ: begin
          // Request held untouched while the slave stalls.
          if (!avm_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= LAT;
          end
        end
        LAT: begin
          sample_q     <= avm_readdata[DATA_W-1:0];
          sample_vld_q <= 1'b1;
          state_q      <= EVAL;
        end
        EVAL: state_q <= IDLE;
        default: begin
          read_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = read_q;

  alarm_debounce_cnt #(
    .DATA_W      (DATA_W),
    .STABLE_POLLS(STABLE_POLLS)
  ) u_deb (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample_q),
    .sample_valid(sample_vld_q),
    .sw_state    (sw_state),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .sw_changed  (sw_changed)
  );

endmodule

// File: tb/tb_alarm_pio_poller.sv
// Bench for alarm_pio_poller: latency-1 Avalon slave model, scoreboard of
// expected switch-change pulses, and directed timing checks.
module tb_alarm_pio_poller;

  localparam int PD = 8;
  localparam int SP = 2;
  localparam int DW = 2;

  typedef struct packed {
    logic [DW-1:0] st;
    logic [DW-1:0] rise;
    logic [DW-1:0] fall;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata;
  logic [DW-1:0] sw_state, sw_rise, sw_fall;
  logic          sw_changed;

  logic [31:0]   rd_q = 32'hFFFF_FFFC;
  logic [DW-1:0] slave_val = '0;
  int            n_reads = 0;
  int            n_pulse = 0;
  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_state = '0;
  exp_t          sb[$];
  exp_t          e_m;

  always #5 clk = ~clk;

  alarm_pio_poller #(.POLL_DIV(PD), .STABLE_POLLS(SP), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .sw_state       (sw_state),
    .sw_rise        (sw_rise),
    .sw_fall        (sw_fall),
    .sw_changed     (sw_changed)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Slave: data valid the cycle after acceptance, upper bits always set.
  assign avm_readdata = rd_q;
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      rd_q    <= 32'hFFFF_FFFC | {30'd0, slave_val};
      n_reads <= n_reads + 1;
    end
  end

  // Scoreboard: every pulse cycle must match the next expected change.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sw_changed || (|sw_rise) || (|sw_fall)) begin
        n_pulse++;
        if (sb.size() == 0) begin
          chk("unexp_pulse", {27'd0, sw_changed, sw_rise, sw_fall}, 32'd0);
        end else begin
          e_m = sb.pop_front();
          chk("sb_state", sw_state, e_m.st);
          chk("sb_rise", sw_rise, e_m.rise);
          chk("sb_fall", sw_fall, e_m.fall);
          chk("sb_changed", sw_changed, 1);
          exp_state = e_m.st;
        end
      end else begin
        chk("sw_hold", sw_state, exp_state);
      end
    end
  end

  // Clock edges until avm_read is seen high (n = edges waited).
  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!avm_read && n < 200);
    if (!avm_read) chk("read_timeout", avm_read, 1);
  endtask

  initial begin
    int n, r0, hi;
    enable = 1'b1;
    slave_val = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_state", sw_state, 0);
    chk("rst_rise", sw_rise, 0);
    chk("rst_fall", sw_fall, 0);
    chk("rst_changed", sw_changed, 0);

    // First read exactly at edge PD after release.
    reset_n = 1'b1;
    for (int k = 1; k <= PD; k++) begin
      @(posedge clk); #1;
      chk("first_read", avm_read, (k == PD));
      chk("addr_zero", avm_address, 0);
    end

    // Second poll of 0x3 makes it stable: 0 -> 3.
    sb.push_back('{2'd3, 2'd3, 2'd0});
    wait_read(n);
    chk("poll_period", n, PD + 3);
    @(posedge clk); #1;
    chk("read_1cyc", avm_read, 0);
    repeat (4) @(posedge clk); #1;
    chk("pulses_a", n_pulse, 1);
    chk("state_a", sw_state, 3);

    // Stalled read: held 6 cycles, single transaction.
    avm_waitrequest = 1'b1;
    r0 = n_reads;
    wait_read(n);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("wr_hold_read", avm_read, 1);
      chk("wr_hold_addr", avm_address, 0);
    end
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("wr_release", avm_read, 0);
    repeat (3) @(posedge clk); #1;
    chk("wr_one_read", n_reads - r0, 1);

    // Flip-flopping candidate never becomes stable.
    for (int i = 0; i < 6; i++) begin
      slave_val = (i % 2 == 0) ? 2'd1 : 2'd0;
      wait_read(n);
      repeat (3) @(posedge clk);
    end
    repeat (2) @(negedge clk); #1;
    chk("alt_state", sw_state, 3);
    chk("alt_pulses", n_pulse, 1);

    // 0x2 twice: bit 0 falls.
    slave_val = 2'd2;
    sb.push_back('{2'd2, 2'd0, 2'd1});
    for (int i = 0; i < 2; i++) begin
      wait_read(n);
      repeat (3) @(posedge clk);
    end
    repeat (2) @(negedge clk); #1;
    chk("fall_pulses", n_pulse, 2);
    chk("fall_state", sw_state, 2);

    // Enable dropped during LAT: transaction completes, then idle.
    slave_val = 2'd1;
    r0 = n_reads;
    wait_read(n);
    @(posedge clk); #1;
    enable = 1'b0;
    hi = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (avm_read) hi++;
    end
    chk("dis_no_read", hi, 0);
    chk("dis_one_read", n_reads - r0, 1);
    sb.push_back('{2'd1, 2'd1, 2'd2});
    enable = 1'b1;
    wait_read(n);
    chk("reen_latency", n, PD);
    repeat (3) @(posedge clk);
    repeat (2) @(negedge clk); #1;
    chk("reen_pulses", n_pulse, 3);
    chk("reen_state", sw_state, 1);

    // Reset during a stalled read drops it at once; it never resumes.
    avm_waitrequest = 1'b1;
    r0 = n_reads;
    wait_read(n);
    #2;
    reset_n = 1'b0;
    exp_state = '0;
    #1;
    chk("mid_rst_read", avm_read, 0);
    chk("mid_rst_addr", avm_address, 0);
    chk("mid_rst_state", sw_state, 0);
    chk("mid_rst_pulse", {sw_changed, sw_rise, sw_fall}, 0);
    repeat (2) @(negedge clk);
    avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    for (int k = 1; k <= PD; k++) begin
      @(posedge clk); #1;
      chk("post_rst_read", avm_read, (k == PD));
    end
    chk("aborted_read", n_reads - r0, 0);
    repeat (6) @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_pio_poller.md
ALARM_PIO_POLLER -- requirements
Module: alarm_pio_poller

Interface
REQ-001 Parameter POLL_DIV, default 50000, meaning: clk cycles between successive poll reads (>=4).
REQ-002 Parameter STABLE_POLLS, default 4, meaning: consecutive identical samples required to accept a new switch value (1..15).
REQ-003 Parameter DATA_W, default 2, meaning: number of switch bits taken from readdata[DATA_W-1:0].
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = polling runs; low = poller idles after any in-flight read completes.
REQ-007 avm_address  output  2  Avalon-MM master address; constant 0 (data register).
REQ-008 avm_read  output  1  Avalon-MM read request.
REQ-009 avm_waitrequest  input  1  slave stall; request held while high.
REQ-010 avm_readdata  input  32  slave read data; valid exactly 1 cycle after the cycle read is accepted (fixed read latency 1).
REQ-011 sw_state  output  DATA_W  debounced switch value.
REQ-012 sw_rise  output  DATA_W  one-cycle pulse per bit that went 0->1 in sw_state.
REQ-013 sw_fall  output  DATA_W  one-cycle pulse per bit that went 1->0 in sw_state.
REQ-014 sw_changed  output  1  one-cycle pulse, OR of sw_rise and sw_fall.

Function
REQ-015 States SHALL be IDLE, REQ, LAT, EVAL.
REQ-016 IDLE: interval counter SHALL count POLL_DIV-1 down to 0; at 0 with enable high go to REQ and reload; with enable low counter holds at reload value.
REQ-017 REQ: avm_read SHALL be 1; read accepted in a cycle with avm_waitrequest=0, then go to LAT; avm_read and avm_address SHALL be stable while waitrequest=1.
REQ-018 LAT: avm_read SHALL be 0; avm_readdata[DATA_W-1:0] SHALL be captured as sample; go to EVAL.
REQ-019 EVAL: if sample equals candidate, stable counter increments (saturating at STABLE_POLLS); else candidate<=sample and counter<=1.
REQ-020 When counter reaches STABLE_POLLS and candidate differs from sw_state, sw_state SHALL update in the cycle after EVAL, with sw_rise/sw_fall/sw_changed pulsing for exactly that one cycle.
REQ-021 EVAL SHALL return to IDLE unconditionally; poll period = POLL_DIV + cycles spent in REQ/LAT/EVAL is not required to be exact, but start-to-start SHALL be POLL_DIV+3 cycles with zero waitrequest.
REQ-022 avm_readdata bits above DATA_W-1 SHALL be ignored.
REQ-023 enable deasserted during REQ/LAT/EVAL SHALL NOT abort the transaction; the poller finishes EVAL then idles.
REQ-024 A candidate flip-flopping every poll SHALL never update sw_state.
REQ-025 STABLE_POLLS=1 SHALL update sw_state on the first differing sample.

Reset
REQ-026 On reset_n low: state IDLE, avm_read 0, avm_address 0, interval counter POLL_DIV-1, stable counter 0, candidate 0, sw_state 0, sw_rise/sw_fall/sw_changed 0.
REQ-027 Reset asserted mid-REQ SHALL drop avm_read immediately (asynchronous); no transaction resumes after release.
REQ-028 First poll after release SHALL start POLL_DIV cycles after the first clk edge with reset_n high and enable high.

Structure
REQ-029 State encoding enum and DATA_W default SHALL live in shared package alarm_pkg.
REQ-030 Debounce (candidate, stable counter, sw_state, edge pulses) SHALL be a sub-module alarm_debounce_cnt with inputs sample, sample_valid; the FSM/Avalon master stays in the top.

Verification
REQ-031 POLL_DIV=8, STABLE_POLLS=2, slave readdata=0x3, no waitrequest -> avm_read high 1 cycle at cycle 8 after reset; sw_state 0->3 after 2nd poll, sw_rise=2'b11 one cycle, sw_changed one cycle.
REQ-032 waitrequest held high 5 cycles during REQ -> avm_read stays 1 for 6 cycles, address 0 throughout, one read only.
REQ-033 Samples alternating 0x1,0x0 each poll, STABLE_POLLS=2 -> sw_state stays 0, no pulses.
REQ-034 sw_state=3, readdata becomes 0x2 for 2 polls -> sw_fall=2'b01 one cycle, sw_rise=0, sw_state=2.
REQ-035 enable=0 dropped during LAT -> EVAL completes, no further avm_read until enable=1 and POLL_DIV cycles elapse.
REQ-036 reset_n low while avm_read=1 -> avm_read 0 same cycle, all outputs 0; readdata upper bits 0xFFFFFFFC ignored in all tests.
